// File: rtl/down_counter_timer.sv
// Loadable down-counter timer: counts a start value down once per DIV enabled clocks,
// pulses done on reaching zero, then stops or reloads the last loaded value.
module down_counter_timer #(
    parameter int WIDTH       = 4,
    parameter int DIV         = 1,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             stop,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    // A one-bit prescaler is kept for DIV==1; it simply never leaves zero.
    localparam int             PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PS_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] reload, reload_n;
    logic [PW-1:0]    presc, presc_n;
    logic             done_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            presc  <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            reload <= reload_n;
            presc  <= presc_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload;
        presc_n  = presc;
        done_n   = 1'b0;

        if (load) begin
            count_n  = load_val;
            reload_n = load_val;
            presc_n  = '0;
            if (load_val != '0) begin
                state_n = RUN;
            end else begin
                // Zero start value expires immediately without entering RUN.
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end else if (stop) begin
            state_n = IDLE;
        end else if (state == RUN && en) begin
            if (presc == PS_LAST) begin
                presc_n = '0;
                if (count == ONE) begin
                    done_n = 1'b1;
                    if (AUTO_RELOAD) begin
                        count_n = reload;
                    end else begin
                        count_n = '0;
                        state_n = IDLE;
                    end
                end else begin
                    count_n = count - ONE;
                end
            end else begin
                presc_n = presc + PW'(1);
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: three parameterisations driven in parallel, checked every
// cycle against a remaining-clocks model, plus literal expectations for the key scenarios.
module tb_down_counter_timer;

    logic       clk = 1'b0;
    logic       rst, load, stop, en;
    logic [3:0] load_val;
    logic [3:0] count0, count1, count2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    down_counter_timer #(.WIDTH(4), .DIV(1), .AUTO_RELOAD(1'b0)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .stop(stop), .en(en),
        .count(count0), .busy(busy0), .done(done0)
    );

    down_counter_timer #(.WIDTH(4), .DIV(3), .AUTO_RELOAD(1'b0)) u_div3 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .stop(stop), .en(en),
        .count(count1), .busy(busy1), .done(done1)
    );

    down_counter_timer #(.WIDTH(4), .DIV(1), .AUTO_RELOAD(1'b1)) u_ar (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .stop(stop), .en(en),
        .count(count2), .busy(busy2), .done(done2)
    );

    // Model state: a run is "rem enabled clocks left until expiry"; the shown count is
    // the number of ticks still pending, i.e. ceil(rem / DIV).
    typedef struct {
        bit run;
        int rem;
        int held;
        int reload;
        bit done;
    } model_t;

    model_t m0, m1, m2;

    function automatic int shown(model_t m, int div);
        return m.run ? (m.rem + div - 1) / div : m.held;
    endfunction

    function automatic model_t step(model_t m, int div, bit ar);
        model_t n;
        n = m;
        n.done = 1'b0;
        if (rst !== 1'b1) begin
            n.run    = 1'b0;
            n.rem    = 0;
            n.held   = 0;
            n.reload = 0;
        end else if (load) begin
            n.reload = int'(load_val);
            if (load_val != 4'd0) begin
                n.run = 1'b1;
                n.rem = n.reload * div;
            end else begin
                n.run  = 1'b0;
                n.held = 0;
                n.done = 1'b1;
            end
        end else if (stop) begin
            if (m.run) n.held = shown(m, div);
            n.run = 1'b0;
        end else if (m.run && en) begin
            n.rem = m.rem - 1;
            if (n.rem == 0) begin
                n.done = 1'b1;
                if (ar) begin
                    n.rem = m.reload * div;
                end else begin
                    n.run  = 1'b0;
                    n.held = 0;
                end
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        m0 = step(m0, 1, 1'b0);
        m1 = step(m1, 3, 1'b0);
        m2 = step(m2, 1, 1'b1);
        #1;
        check("model u0 count", 32'(count0), 32'(shown(m0, 1)));
        check("model u0 busy",  32'(busy0),  32'(m0.run));
        check("model u0 done",  32'(done0),  32'(m0.done));
        check("model div3 count", 32'(count1), 32'(shown(m1, 3)));
        check("model div3 busy",  32'(busy1),  32'(m1.run));
        check("model div3 done",  32'(done1),  32'(m1.done));
        check("model ar count", 32'(count2), 32'(shown(m2, 1)));
        check("model ar busy",  32'(busy2),  32'(m2.run));
        check("model ar done",  32'(done2),  32'(m2.done));
    end

    initial begin
        int exp3[7];
        int exp4[8];
        int dpulses;
        int dat;
        exp3 = '{2, 2, 2, 1, 1, 1, 0};
        exp4 = '{3, 2, 1, 3, 2, 1, 3, 2};

        // Reset held with load and en asserted
        rst = 1'b0; load = 1'b1; en = 1'b1; stop = 1'b0; load_val = 4'd7;
        repeat (2) begin
            @(negedge clk);
            check("rst count", 32'(count0), 32'd0);
            check("rst busy",  32'(busy0),  32'd0);
            check("rst done",  32'(done0),  32'd0);
        end
        rst = 1'b1; load = 1'b0;
        @(negedge clk);
        check("post-rst count", 32'(count0), 32'd0);
        check("post-rst busy",  32'(busy0),  32'd0);

        // DIV=1 countdown from 5
        load = 1'b1; load_val = 4'd5;
        @(negedge clk);
        load = 1'b0;
        check("t2 load count", 32'(count0), 32'd5);
        check("t2 load busy",  32'(busy0),  32'd1);
        for (int k = 4; k >= 0; k--) begin
            @(negedge clk);
            check("t2 count", 32'(count0), 32'(k));
            check("t2 done",  32'(done0),  32'(k == 0));
        end
        check("t2 busy at expiry", 32'(busy0), 32'd0);
        @(negedge clk);
        check("t2 done after", 32'(done0), 32'd0);
        check("t2 count hold", 32'(count0), 32'd0);

        // DIV=3 countdown from 2
        load = 1'b1; load_val = 4'd2;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            check("t3 div3 count", 32'(count1), 32'(exp3[i]));
            check("t3 div3 done",  32'(done1),  32'(i == 6));
        end

        // DIV=3 with en low for 4 clocks mid-run
        load = 1'b1; load_val = 4'd2;
        @(negedge clk);
        load = 1'b0;
        dpulses = 0;
        dat = -1;
        for (int i = 1; i <= 14; i++) begin
            en = (i >= 3 && i <= 6) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (done1 === 1'b1) begin
                dpulses++;
                dat = i;
            end
        end
        en = 1'b1;
        check("t3 freeze done cycle", 32'(dat), 32'd10);
        check("t3 freeze done pulses", 32'(dpulses), 32'd1);

        // Auto reload from 3, then stop
        load = 1'b1; load_val = 4'd3;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check("t4 ar count", 32'(count2), 32'(exp4[i]));
            check("t4 ar done",  32'(done2),  32'(i == 3 || i == 6));
            check("t4 ar busy",  32'(busy2),  32'd1);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t4 stop busy",  32'(busy2),  32'd0);
        check("t4 stop count", 32'(count2), 32'd2);
        check("t4 stop done",  32'(done2),  32'd0);
        @(negedge clk);
        check("t4 idle hold", 32'(count2), 32'd2);

        // Zero load: immediate expiry
        load = 1'b1; load_val = 4'd0;
        @(negedge clk);
        load = 1'b0;
        check("t5 zero done",  32'(done0),  32'd1);
        check("t5 zero busy",  32'(busy0),  32'd0);
        check("t5 zero count", 32'(count0), 32'd0);
        @(negedge clk);
        check("t5 zero done after", 32'(done0), 32'd0);

        // Full-scale load, no wrap
        load = 1'b1; load_val = 4'd15;
        @(negedge clk);
        load = 1'b0;
        check("t5 max count", 32'(count0), 32'd15);
        for (int k = 14; k >= 0; k--) begin
            @(negedge clk);
            check("t5 max count", 32'(count0), 32'(k));
        end
        check("t5 max done", 32'(done0), 32'd1);
        @(negedge clk);
        check("t5 no wrap count", 32'(count0), 32'd0);
        check("t5 no wrap busy",  32'(busy0),  32'd0);

        // Load and stop on the same edge
        load = 1'b1; stop = 1'b1; load_val = 4'd4;
        @(negedge clk);
        load = 1'b0; stop = 1'b0;
        check("t5 load>stop busy",  32'(busy0),  32'd1);
        check("t5 load>stop count", 32'(count0), 32'd4);

        // Reload during run at count 2
        repeat (2) @(negedge clk);
        check("t5 pre-reload count", 32'(count0), 32'd2);
        load = 1'b1; load_val = 4'd9;
        @(negedge clk);
        load = 1'b0;
        check("t5 reload count", 32'(count0), 32'd9);
        check("t5 reload done",  32'(done0),  32'd0);
        check("t5 reload busy",  32'(busy0),  32'd1);

        // Reset mid-run at count 3
        repeat (6) @(negedge clk);
        check("t6 pre-reset count", 32'(count0), 32'd3);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("t6 reset count", 32'(count0), 32'd0);
        check("t6 reset busy",  32'(busy0),  32'd0);
        check("t6 reset done",  32'(done0),  32'd0);
        @(negedge clk);
        check("t6 no late done", 32'(done0), 32'd0);

        // Randomised traffic, checked every cycle by the model
        repeat (3000) begin
            rst      = ($urandom_range(0, 63) != 0);
            load     = ($urandom_range(0, 9) == 0);
            load_val = 4'($urandom_range(0, 15));
            stop     = ($urandom_range(0, 19) == 0);
            en       = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        rst = 1'b1; load = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
